// File: rtl/mem_io_responder.sv
// Byte-wide CPU memory responder: 128 KB RAM, UART TX FIFO, cycle counter and stop register.
// Optional RX FIFO on UART reads, enabled by defining MEM_IO_RX_FIFO_EN.
module mem_io_responder #(
    parameter int RAM_ADDR_W    = 17,
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 3,
    parameter int FULL_MARGIN   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        prog_done,
    output logic [31:0] cycle_cnt
);

    localparam int TX_DEPTH    = 1 << TX_DEPTH_LOG2;
    localparam int TX_NEAR_INT = TX_DEPTH - FULL_MARGIN;
    localparam logic [TX_DEPTH_LOG2:0] TX_FULL_CNT = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
    localparam logic [TX_DEPTH_LOG2:0] TX_ONE      = {{TX_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [TX_DEPTH_LOG2:0] TX_NEAR_CNT = TX_NEAR_INT[TX_DEPTH_LOG2:0];
    localparam logic [17:0] ADDR_UART = 18'h30000;
    localparam logic [17:0] ADDR_CNT0 = 18'h30004;
    localparam logic [17:0] ADDR_CNT1 = 18'h30005;
    localparam logic [17:0] ADDR_CNT2 = 18'h30006;
    localparam logic [17:0] ADDR_CNT3 = 18'h30007;

    logic [7:0]  ram_q [0:(1 << RAM_ADDR_W)-1];
    logic [7:0]  tx_mem_q [0:TX_DEPTH-1];

    logic [7:0]  mem_din_q, mem_din_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] snap_q, snap_d;
    logic        prog_done_q, prog_done_d;
    logic        io_full_q, io_full_d;
    logic [TX_DEPTH_LOG2:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;

    logic                   io_s, cpu_wr_s, cpu_rd_s, ram_we_s, uart_wr_s, stop_wr_s, rx_rd_sel_s;
    logic [17:0]            io_off_s;
    logic [RAM_ADDR_W-1:0]  ram_addr_s;
    logic                   tx_valid_s, tx_full_s, tx_pop_s, tx_we_s;
    logic [TX_DEPTH_LOG2-1:0] tx_widx_s;
    logic [TX_DEPTH_LOG2:0] tx_last_s, tx_count_d;
    logic [7:0]             tx_wdata_s, rx_head_s;
    logic                   unused_s;

    assign io_off_s    = mem_a[17:0];
    assign io_s        = (mem_a[17:16] == 2'b11);
    assign ram_addr_s  = mem_a[RAM_ADDR_W-1:0];
    assign cpu_wr_s    = rdy_in & mem_wr;
    assign cpu_rd_s    = rdy_in & ~mem_wr;
    assign ram_we_s    = cpu_wr_s & ~io_s;
    assign uart_wr_s   = cpu_wr_s & (io_off_s == ADDR_UART);
    assign stop_wr_s   = cpu_wr_s & (io_off_s == ADDR_CNT0);
    assign rx_rd_sel_s = cpu_rd_s & (io_off_s == ADDR_UART);

    assign tx_valid_s  = (tx_wr_ptr_q != tx_rd_ptr_q);
    assign tx_full_s   = ((tx_wr_ptr_q - tx_rd_ptr_q) == TX_FULL_CNT);

    // TX FIFO push/pop; the stop write always lands, replacing the newest byte when full
    always_comb begin
        tx_pop_s    = tx_valid_s & tx_ready;
        tx_we_s     = 1'b0;
        tx_widx_s   = tx_wr_ptr_q[TX_DEPTH_LOG2-1:0];
        tx_wdata_s  = mem_dout;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_last_s   = tx_wr_ptr_q - TX_ONE;
        if (stop_wr_s) begin
            tx_we_s    = 1'b1;
            tx_wdata_s = 8'h00;
            if (tx_full_s && !tx_pop_s) begin
                tx_widx_s = tx_last_s[TX_DEPTH_LOG2-1:0];
            end else begin
                tx_wr_ptr_d = tx_wr_ptr_q + TX_ONE;
            end
        end else if (uart_wr_s && (mem_dout != 8'h00) && (!tx_full_s || tx_pop_s)) begin
            tx_we_s     = 1'b1;
            tx_wr_ptr_d = tx_wr_ptr_q + TX_ONE;
        end else begin
            tx_we_s = 1'b0;
        end
        if (tx_pop_s) begin
            tx_rd_ptr_d = tx_rd_ptr_q + TX_ONE;
        end else begin
            tx_rd_ptr_d = tx_rd_ptr_q;
        end
        tx_count_d = tx_wr_ptr_d - tx_rd_ptr_d;
        io_full_d  = (tx_count_d >= TX_NEAR_CNT);
    end

    // Read mux, counter snapshot, stop flag and cycle counter
    always_comb begin
        mem_din_d   = mem_din_q;
        snap_d      = snap_q;
        prog_done_d = prog_done_q | stop_wr_s;
        cycle_cnt_d = rdy_in ? (cycle_cnt_q + 32'd1) : cycle_cnt_q;
        if (cpu_rd_s) begin
            if (io_s) begin
                case (io_off_s)
                    ADDR_UART: mem_din_d = rx_head_s;
                    ADDR_CNT0: begin
                        mem_din_d = cycle_cnt_q[7:0];
                        snap_d    = cycle_cnt_q;
                    end
                    ADDR_CNT1: mem_din_d = snap_q[15:8];
                    ADDR_CNT2: mem_din_d = snap_q[23:16];
                    ADDR_CNT3: mem_din_d = snap_q[31:24];
                    default:   mem_din_d = 8'h00;
                endcase
            end else begin
                mem_din_d = ram_q[ram_addr_s];
            end
        end else begin
            mem_din_d = mem_din_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            mem_din_q   <= 8'h00;
            cycle_cnt_q <= 32'h0000_0000;
            snap_q      <= 32'h0000_0000;
            prog_done_q <= 1'b0;
            io_full_q   <= 1'b0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
        end else begin
            mem_din_q   <= mem_din_d;
            cycle_cnt_q <= cycle_cnt_d;
            snap_q      <= snap_d;
            prog_done_q <= prog_done_d;
            io_full_q   <= io_full_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
        end
    end

    // Storage arrays carry no reset; pointers define their valid contents
    always_ff @(posedge clk_in) begin
        if (ram_we_s) begin
            ram_q[ram_addr_s] <= mem_dout;
        end
        if (tx_we_s) begin
            tx_mem_q[tx_widx_s] <= tx_wdata_s;
        end
    end

`ifdef MEM_IO_RX_FIFO_EN
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam logic [RX_DEPTH_LOG2:0] RX_FULL_CNT = {1'b1, {RX_DEPTH_LOG2{1'b0}}};
    localparam logic [RX_DEPTH_LOG2:0] RX_ONE      = {{RX_DEPTH_LOG2{1'b0}}, 1'b1};

    logic [7:0]             rx_mem_q [0:RX_DEPTH-1];
    logic [RX_DEPTH_LOG2:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic                   rx_ready_q, rx_ready_d, rx_empty_s, rx_push_s, rx_pop_s;

    // RX FIFO: UART pushes while not full, CPU pops on 0x30000 reads
    always_comb begin
        rx_empty_s = (rx_wr_ptr_q == rx_rd_ptr_q);
        rx_push_s  = rx_valid & rx_ready_q;
        rx_pop_s   = rx_rd_sel_s & ~rx_empty_s;
        rx_head_s  = rx_empty_s ? 8'h00 : rx_mem_q[rx_rd_ptr_q[RX_DEPTH_LOG2-1:0]];
        if (rx_push_s) begin
            rx_wr_ptr_d = rx_wr_ptr_q + RX_ONE;
        end else begin
            rx_wr_ptr_d = rx_wr_ptr_q;
        end
        if (rx_pop_s) begin
            rx_rd_ptr_d = rx_rd_ptr_q + RX_ONE;
        end else begin
            rx_rd_ptr_d = rx_rd_ptr_q;
        end
        rx_ready_d = ((rx_wr_ptr_d - rx_rd_ptr_d) != RX_FULL_CNT);
    end

    // RX pointer and ready registers
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_ready_q  <= 1'b0;
        end else begin
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_ready_q  <= rx_ready_d;
        end
    end

    // RX storage
    always_ff @(posedge clk_in) begin
        if (rx_push_s) begin
            rx_mem_q[rx_wr_ptr_q[RX_DEPTH_LOG2-1:0]] <= rx_data;
        end
    end

    assign rx_ready = rx_ready_q;
    assign unused_s = ^{mem_a[31:18]};
`else
    assign rx_head_s = 8'h00;
    assign rx_ready  = 1'b0;
    assign unused_s  = ^{mem_a[31:18], rx_data, rx_valid, rx_rd_sel_s, (RX_DEPTH_LOG2 != 0)};
`endif

    assign mem_din        = mem_din_q;
    assign io_buffer_full = io_full_q;
    assign tx_valid       = tx_valid_s;
    assign tx_data        = tx_mem_q[tx_rd_ptr_q[TX_DEPTH_LOG2-1:0]];
    assign prog_done      = prog_done_q;
    assign cycle_cnt      = cycle_cnt_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: read and TX expectations queued by stimulus, checked by a monitor.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in_n, rdy_in, mem_wr, tx_ready, rx_valid;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout, rx_data;
    logic [7:0]  mem_din, tx_data;
    logic        io_buffer_full, tx_valid, rx_ready, prog_done;
    logic [31:0] cycle_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_rd[$];
    logic [7:0]  exp_tx[$];
    bit          chk_rd = 1'b0;
    bit          rd_pend = 1'b0;
    logic [31:0] c0;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .rdy_in(rdy_in), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .prog_done(prog_done), .cycle_cnt(cycle_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic op(input logic [31:0] a, input logic [7:0] d, input logic w);
        mem_a = a; mem_dout = d; mem_wr = w; chk_rd = 1'b0;
        step();
    endtask

    task automatic idle();
        op(32'h0001_FFF0, 8'h00, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] e);
        mem_a = a; mem_dout = 8'h00; mem_wr = 1'b0; chk_rd = 1'b1;
        exp_rd.push_back(e);
        step();
        chk_rd = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] d);
        op(32'h0003_0000, d, 1'b1);
        if (d != 8'h00) exp_tx.push_back(d);
    endtask

    // Monitor: compares registered read data and every byte the UART accepts
    always @(negedge clk_in) begin
        logic [7:0] e;
        if (rd_pend) begin
            if (exp_rd.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL mem_din: got %h with no expected read", mem_din);
            end else begin
                e = exp_rd.pop_front();
                n_vec++;
                if (mem_din !== e) begin
                    n_err++;
                    $display("FAIL mem_din: got %h expected %h (addr hist)", mem_din, e);
                end
            end
        end
        rd_pend = chk_rd && rdy_in && rst_in_n;
        if (rst_in_n && tx_valid && tx_ready) begin
            n_vec++;
            if (exp_tx.size() == 0) begin
                n_err++;
                $display("FAIL tx_data: got %h with no expected byte", tx_data);
            end else begin
                e = exp_tx.pop_front();
                if (tx_data !== e) begin
                    n_err++;
                    $display("FAIL tx_data: got %h expected %h", tx_data, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in_n = 1'b0; rdy_in = 1'b1; mem_a = 32'h0; mem_dout = 8'h00; mem_wr = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #12;
        check("rst_mem_din", {24'h0, mem_din}, 32'h0);
        check("rst_io_full", {31'h0, io_buffer_full}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("rst_prog_done", {31'h0, prog_done}, 32'h0);
        check("rst_cycle_cnt", cycle_cnt, 32'h0);
        rst_in_n = 1'b1;
        step();

        // RAM write/read, read-after-write and streaming reads
        op(32'h0000_0010, 8'hA5, 1'b1);
        rd(32'h0000_0010, 8'hA5);
        op(32'h0000_0000, 8'h11, 1'b1);
        op(32'h0000_0001, 8'h22, 1'b1);
        op(32'h0000_0002, 8'h33, 1'b1);
        op(32'h0000_0003, 8'h44, 1'b1);
        rd(32'h0000_0000, 8'h11);
        rd(32'h0000_0001, 8'h22);
        rd(32'h0000_0002, 8'h33);
        rd(32'h0000_0003, 8'h44);

        // TX: zero byte ignored
        tx_ready = 1'b1;
        push_tx(8'h48);
        push_tx(8'h69);
        push_tx(8'h00);
        repeat (4) idle();
        check("tx_idle", {31'h0, tx_valid}, 32'h0);

        // Fill to threshold, overflow drop, stop overwriting the newest slot
        tx_ready = 1'b0;
        for (int i = 1; i <= 13; i++) push_tx(8'(i));
        check("full_at_13", {31'h0, io_buffer_full}, 32'h0);
        push_tx(8'd14);
        check("full_at_14", {31'h0, io_buffer_full}, 32'h1);
        push_tx(8'd15);
        push_tx(8'd16);
        op(32'h0003_0000, 8'h77, 1'b1);
        check("prog_done_pre", {31'h0, prog_done}, 32'h0);
        op(32'h0003_0004, 8'hEE, 1'b1);
        exp_tx[exp_tx.size()-1] = 8'h00;
        check("prog_done_set", {31'h0, prog_done}, 32'h1);
        check("full_held", {31'h0, io_buffer_full}, 32'h1);
        tx_ready = 1'b1;
        repeat (20) idle();
        check("tx_drained", 32'(exp_tx.size()), 32'h0);
        check("full_clear", {31'h0, io_buffer_full}, 32'h0);
        push_tx(8'h5A);
        repeat (3) idle();
        check("prog_done_sticky", {31'h0, prog_done}, 32'h1);
        check("tx_after_stop", {31'h0, tx_valid}, 32'h0);

        // Counter snapshot
        for (int g = 0; g < 1000 && cycle_cnt != 32'h0000_01FF; g++) idle();
        check("cnt_reach", cycle_cnt, 32'h0000_01FF);
        rd(32'h0003_0004, 8'hFF);
        rd(32'h0003_0005, 8'h01);
        rd(32'h0003_0006, 8'h00);
        rd(32'h0003_0007, 8'h00);
        rd(32'h0003_0008, 8'h00);

        // Counter wrap
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt_q;
        idle();
        check("cnt_wrap", cycle_cnt, 32'h0);
        idle();
        check("cnt_after_wrap", cycle_cnt, 32'h1);

        // rdy_in low suppresses CPU-side effects
        op(32'h0000_0020, 8'h3C, 1'b1);
        c0 = cycle_cnt;
        rdy_in = 1'b0;
        op(32'h0000_0020, 8'h5A, 1'b1);
        op(32'h0003_0000, 8'h66, 1'b1);
        idle();
        check("cnt_frozen", cycle_cnt - c0, 32'h0);
        check("no_tx_push", {31'h0, tx_valid}, 32'h0);
        rdy_in = 1'b1;
        rd(32'h0000_0020, 8'h3C);
        check("cnt_resume", cycle_cnt - c0, 32'h1);

        // RX path
`ifdef MEM_IO_RX_FIFO_EN
        check("rx_ready_on", {31'h0, rx_ready}, 32'h1);
        rx_valid = 1'b1; rx_data = 8'h31;
        idle();
        rx_data = 8'h32;
        idle();
        rx_valid = 1'b0;
        rd(32'h0003_0000, 8'h31);
        rd(32'h0003_0000, 8'h32);
        rd(32'h0003_0000, 8'h00);
`else
        check("rx_ready_off", {31'h0, rx_ready}, 32'h0);
        rx_valid = 1'b1; rx_data = 8'h31;
        idle();
        idle();
        rx_valid = 1'b0;
        rd(32'h0003_0000, 8'h00);
        rd(32'h0003_0000, 8'h00);
`endif
        idle();

        // Asynchronous reset in the middle of a TX burst
        tx_ready = 1'b0;
        push_tx(8'hA1);
        push_tx(8'hA2);
        push_tx(8'hA3);
        check("burst_valid", {31'h0, tx_valid}, 32'h1);
        #2;
        exp_tx.delete();
        rst_in_n = 1'b0;
        #1;
        check("mrst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("mrst_prog_done", {31'h0, prog_done}, 32'h0);
        check("mrst_mem_din", {24'h0, mem_din}, 32'h0);
        check("mrst_cycle_cnt", cycle_cnt, 32'h0);
        #3;
        rst_in_n = 1'b1;
        tx_ready = 1'b1;
        repeat (3) idle();
        check("post_rst_empty", {31'h0, tx_valid}, 32'h0);
        check("post_rst_full", {31'h0, io_buffer_full}, 32'h0);

        for (int g = 0; g < 50 && exp_tx.size() != 0; g++) idle();
        check("tx_queue_empty", 32'(exp_tx.size()), 32'h0);
        check("rd_queue_empty", 32'(exp_rd.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Bus-side responder for the CPU's byte-wide memory interface (mem_a / mem_dout / mem_din / mem_wr).
- Serves RAM with a registered 1-cycle read and a 1-cycle write.
- Decodes the I/O window at addr[17:16]==2'b11:
  - 0x30000: UART TX push / RX pop.
  - 0x30004: cycle counter read / program stop.
- Drives io_buffer_full back to the CPU; streams bytes to and from the UART through valid/ready handshakes.

Parameters:
- RAM_ADDR_W, 17, RAM byte-address width (128 KB array).
- TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (16 entries).
- RX_DEPTH_LOG2, 3, log2 of RX FIFO depth (8 entries); used only with MEM_IO_RX_FIFO_EN.
- FULL_MARGIN, 2, free TX slots at or below which io_buffer_full asserts.

Ports:
- clk_in  in  1  system clock.
- rst_in_n  in  1  asynchronous active-low reset.
- rdy_in  in  1  CPU ready; when low, all side effects are suppressed.
- mem_a  in  32  byte address from CPU; only [17:0] decoded.
- mem_dout  in  8  write data from CPU.
- mem_wr  in  1  1 = write, 0 = read.
- mem_din  out  8  read data to CPU, valid the cycle after the address.
- io_buffer_full  out  1  TX FIFO nearly full.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART accepts byte.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  responder accepts rx byte.
- prog_done  out  1  sticky; program issued stop.
- cycle_cnt  out  32  free-running cycle counter.

Behaviour:
- Reset (rst_in_n low, asynchronous) clears:
  - mem_din=0, io_buffer_full=0, tx_valid=0, rx_ready=0, prog_done=0, cycle_cnt=0.
  - Both FIFO pointers and the counter snapshot.
  - RAM contents are not cleared.
- Decode, effective only when rdy_in=1:
  - io = (mem_a[17:16]==2'b11); otherwise RAM at mem_a[RAM_ADDR_W-1:0].
- RAM write: array updated at the clock edge of the cycle where mem_wr=1; no wait states.
- RAM read: mem_din <= ram[addr] at the edge. The CPU samples it next cycle, so back-to-back reads stream one byte per cycle.
- Read-after-write to the same address on consecutive cycles returns the new data.
- Write 0x30000:
  - Nonzero byte: pushed into the TX FIFO.
  - 0x00: ignored.
  - Push when the FIFO is full: byte dropped. This is a protocol error; the CPU is expected to honour io_buffer_full.
- Write 0x30004:
  - Pushes 0x00 into the TX FIFO, even if the FIFO is full (it overwrites the last slot).
  - Sets prog_done=1 (sticky until reset).
  - Later 0x30000 writes are still accepted.
- Read 0x30000: mem_din <= RX FIFO head, then pop. Reading an empty FIFO returns 0x00 and does not move pointers.
- Read 0x30004..0x30007:
  - A read of 0x30004 latches snapshot=cycle_cnt and returns snapshot[7:0] computed from the live value.
  - 0x30005, 0x30006, 0x30007 return snapshot bytes 1, 2, 3, giving a coherent dword.
  - Other I/O addresses read 0x00; writes to them are ignored.
- cycle_cnt: increments every clock with rdy_in=1, wraps 0xFFFFFFFF to 0, and keeps counting after prog_done.
- io_buffer_full: registered, = (free TX slots <= FULL_MARGIN), updated every edge.
- TX handshake:
  - tx_valid = TX FIFO not empty; tx_data = head.
  - Pop on tx_valid && tx_ready.
  - A simultaneous push and pop on a full FIFO is legal: both take effect and the count is unchanged.
- rdy_in=0: no RAM writes, no FIFO push or pop from the CPU side, mem_din holds, counter holds. The UART-side handshakes continue.
- Mid-operation reset: FIFOs are emptied and in-flight bytes lost; tx_valid drops asynchronously.

Optional Feature:
- Macro MEM_IO_RX_FIFO_EN.
- Defined:
  - An RX FIFO of 2^RX_DEPTH_LOG2 entries is instantiated.
  - rx_ready = not full; push on rx_valid && rx_ready.
  - A push and a CPU pop in the same cycle both take effect.
- Undefined:
  - No RX FIFO; rx_ready is tied 0.
  - 0x30000 reads always return 0x00; rx_data and rx_valid are ignored.

Test Plan:
- RAM: write 0xA5 to 0x00010, read 0x00010 next cycle -> mem_din=0xA5 one cycle after the read address. Burst-read 0x0..0x3 after preloading 11,22,33,44 -> mem_din 0x11,0x22,0x33,0x44 on consecutive cycles.
- TX: write 'H','i',0x00 to 0x30000 with tx_ready=1 -> tx_data emits 0x48 then 0x69 only. Hold tx_ready=0 and push 14 bytes -> io_buffer_full=1 from the cycle after the 14th push.
- Stop: write any byte to 0x30004 -> prog_done=1 next cycle, 0x00 appears on tx_data, prog_done stays high.
- Counter: run to cycle_cnt=0x000001FF, read 0x30004..0x30007 on consecutive cycles -> bytes 0xFF,0x01,0x00,0x00 (snapshot, not live). Force the counter to 0xFFFFFFFF -> wraps to 0.
- RX (MEM_IO_RX_FIFO_EN): inject 0x31,0x32, read 0x30000 three times -> 0x31, 0x32, 0x00. Without the macro -> always 0x00 and rx_ready=0.
- rdy_in=0 during a RAM write and a 0x30000 write -> RAM unchanged, no TX push, cycle_cnt frozen. Assert rst_in_n low mid-burst -> tx_valid=0 and FIFOs empty immediately.
